// File: rtl/accel_sched_pkg.sv
// accel_sched_pkg
// Shared types and constants for the adder-accelerator operation scheduler.
//   sched_state_e : transaction sequencer states
//   ACC_ADDR_*    : accelerator register map (op1, op2, result)
//   ACC_ADDR_W / ACC_DATA_W : accelerator port widths
package accel_sched_pkg;

  localparam int ACC_ADDR_W = 11;
  localparam int ACC_DATA_W = 32;

  localparam logic [ACC_ADDR_W-1:0] ACC_ADDR_OP1 = 11'd0;
  localparam logic [ACC_ADDR_W-1:0] ACC_ADDR_OP2 = 11'd1;
  localparam logic [ACC_ADDR_W-1:0] ACC_ADDR_RES = 11'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_OP1   = 3'd1,
    WR_OP2   = 3'd2,
    RD_RES   = 3'd3,
    WAIT_RES = 3'd4,
    RESP     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/accel_rr_arbiter.sv
// accel_rr_arbiter
// Purely combinational round-robin arbiter: grants the first asserted request
// at or after ptr_i, wrapping around past NUM_REQ-1.
//   req_i       : request vector
//   ptr_i       : highest-priority index this cycle
//   grant_o     : one-hot grant (zero when no request)
//   grant_idx_o : index of the granted request
//   any_grant_o : at least one request present
module accel_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_grant_o
);

  always_comb begin : arb
    int cand;
    cand        = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    // Walk the requesters starting at the pointer; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_grant_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = ID_W'(cand);
        any_grant_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_op_scheduler.sv
// accel_op_scheduler
// Shares one memory-mapped adder accelerator between NUM_REQ requesters.
// A request (op1, op2) is accepted round-robin, then the accelerator is driven
// through write op1 (addr 0), write op2 (addr 1), read result (addr 2); the sum
// is returned tagged with the requester index.
//
// Handshakes: a transfer happens on a rising clka edge where valid and ready
// are both high. req_ready_o is combinational and only ever asserted in IDLE,
// one-hot on the granted requester. rsp_valid_o stays high with data and id
// stable until rsp_ready_i is seen; the next request is accepted no earlier
// than the cycle after that handshake.
//
// Ports:
//   clka, rst_ni            : clock shared with the accelerator; async active-low reset
//   req_valid_i/req_ready_o : per-requester request handshake
//   req_op1_i/req_op2_i     : packed operands, requester i at [32i+31:32i]
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_data_o, rsp_id_o    : sum and requester index
//   acc_ena_o..acc_din_o    : accelerator ena/wea/addra/dina (registered)
//   acc_dout_i              : accelerator douta, valid the cycle after a read
//   busy_o                  : FSM outside IDLE
//
// Build option ACCEL_SCHED_SKIP_EN: shadow the operands last written to the
// accelerator and skip a write whose value the accelerator already holds.
module accel_op_scheduler
  import accel_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clka,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_op1_i,
  input  logic [NUM_REQ*32-1:0]   req_op2_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_data_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    acc_ena_o,
  output logic                    acc_wea_o,
  output logic [ACC_ADDR_W-1:0]   acc_addr_o,
  output logic [ACC_DATA_W-1:0]   acc_din_o,
  input  logic [ACC_DATA_W-1:0]   acc_dout_i,
  output logic                    busy_o
);

  sched_state_e state_q, state_d;

  logic [ID_W-1:0]       rr_ptr_q;
  logic [31:0]           op1_q, op2_q, result_q;
  logic [31:0]           op1_d, op2_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  acc_ena_q, acc_wea_q, rsp_valid_q;
  logic [ACC_ADDR_W-1:0] acc_addr_q;
  logic [ACC_DATA_W-1:0] acc_din_q;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx, next_ptr;
  logic                  any_grant, handshake;
  logic [31:0]           op1_arr [NUM_REQ];
  logic [31:0]           op2_arr [NUM_REQ];

  // Whether each write is still needed; always true without the skip option.
  logic need_op1, need_op2_new, need_op2_held;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op1_arr[g] = req_op1_i[32*g +: 32];
    assign op2_arr[g] = req_op2_i[32*g +: 32];
  end

  accel_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign handshake   = (state_q == IDLE) && any_grant;
  assign req_ready_o = (state_q == IDLE) ? grant : '0;
  assign next_ptr    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  assign op1_d = handshake ? op1_arr[grant_idx] : op1_q;
  assign op2_d = handshake ? op2_arr[grant_idx] : op2_q;
  assign id_d  = handshake ? grant_idx          : id_q;

`ifdef ACCEL_SCHED_SKIP_EN
  // Mirror of the accelerator operand registers; both reset to 0 together.
  logic [31:0] sh_op1_q, sh_op2_q;

  always_ff @(posedge clka or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_op1_q <= '0;
      sh_op2_q <= '0;
    end else begin
      if (state_q == WR_OP1) sh_op1_q <= op1_q;
      if (state_q == WR_OP2) sh_op2_q <= op2_q;
    end
  end

  assign need_op1      = (op1_arr[grant_idx] != sh_op1_q);
  assign need_op2_new  = (op2_arr[grant_idx] != sh_op2_q);
  assign need_op2_held = (op2_q != sh_op2_q);
`else
  assign need_op1      = 1'b1;
  assign need_op2_new  = 1'b1;
  assign need_op2_held = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          if (need_op1)          state_d = WR_OP1;
          else if (need_op2_new) state_d = WR_OP2;
          else                   state_d = RD_RES;
        end
      end
      WR_OP1:   state_d = need_op2_held ? WR_OP2 : RD_RES;
      WR_OP2:   state_d = RD_RES;
      RD_RES:   state_d = WAIT_RES;
      WAIT_RES: state_d = RESP;
      RESP:     if (rsp_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Accelerator and response outputs are decoded from the next state so they
  // are registered and line up with the state they belong to.
  always_ff @(posedge clka or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      id_q        <= '0;
      result_q    <= '0;
      acc_ena_q   <= 1'b0;
      acc_wea_q   <= 1'b0;
      acc_addr_q  <= '0;
      acc_din_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      id_q    <= id_d;
      if (handshake) rr_ptr_q <= next_ptr;
      if (state_q == WAIT_RES) result_q <= acc_dout_i;

      acc_ena_q   <= 1'b0;
      acc_wea_q   <= 1'b0;
      acc_addr_q  <= '0;
      acc_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      case (state_d)
        WR_OP1: begin
          acc_ena_q  <= 1'b1;
          acc_wea_q  <= 1'b1;
          acc_addr_q <= ACC_ADDR_OP1;
          acc_din_q  <= op1_d;
        end
        WR_OP2: begin
          acc_ena_q  <= 1'b1;
          acc_wea_q  <= 1'b1;
          acc_addr_q <= ACC_ADDR_OP2;
          acc_din_q  <= op2_d;
        end
        RD_RES: begin
          acc_ena_q  <= 1'b1;
          acc_addr_q <= ACC_ADDR_RES;
        end
        RESP:    rsp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign acc_ena_o   = acc_ena_q;
  assign acc_wea_o   = acc_wea_q;
  assign acc_addr_o  = acc_addr_q;
  assign acc_din_o   = acc_din_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = result_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_accel_op_scheduler.sv
// tb_accel_op_scheduler
// Directed bench for accel_op_scheduler with a behavioural adder accelerator
// (op1 @0, op2 @1, registered sum on read @2, reset by rst_ni).
// Works in both builds; the skip scenario follows ACCEL_SCHED_SKIP_EN.
module tb_accel_op_scheduler;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clka = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [NUM_REQ-1:0]    req_valid_i = '0;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*32-1:0] req_op1_i = '0;
  logic [NUM_REQ*32-1:0] req_op2_i = '0;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i = 1'b1;
  logic [31:0]           rsp_data_o;
  logic [ID_W-1:0]       rsp_id_o;
  logic                  acc_ena_o, acc_wea_o;
  logic [10:0]           acc_addr_o;
  logic [31:0]           acc_din_o;
  logic [31:0]           acc_dout_i;
  logic                  busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] wr_q[$];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- accelerator model ----------------
  logic [31:0] acc_a, acc_b;
  always_ff @(posedge clka or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_a      <= '0;
      acc_b      <= '0;
      acc_dout_i <= '0;
    end else if (acc_ena_o) begin
      if (acc_wea_o) begin
        if (acc_addr_o == 11'd0) acc_a <= acc_din_o;
        else if (acc_addr_o == 11'd1) acc_b <= acc_din_o;
      end else if (acc_addr_o == 11'd2) begin
        acc_dout_i <= acc_a + acc_b;
      end
    end
  end

  always @(posedge clka) begin
    if (rst_ni && acc_ena_o && acc_wea_o) wr_q.push_back(acc_addr_o);
  end

  accel_op_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clka        (clka),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op1_i   (req_op1_i),
    .req_op2_i   (req_op2_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .acc_ena_o   (acc_ena_o),
    .acc_wea_o   (acc_wea_o),
    .acc_addr_o  (acc_addr_o),
    .acc_din_o   (acc_din_o),
    .acc_dout_i  (acc_dout_i),
    .busy_o      (busy_o)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Issue one request and collect its response (rsp_ready_i assumed high).
  // lat counts cycles from the accept edge to the first rsp_valid_o cycle.
  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic [ID_W-1:0] id,
                       output int lat, output bit ok);
    int w;
    ok = 1'b1; lat = 0; d = '0; id = '0; w = 0;
    req_op1_i[32*r +: 32] = a;
    req_op2_i[32*r +: 32] = b;
    req_valid_i[r] = 1'b1;
    #1;
    while (!req_ready_o[r] && w < 20) begin step(); #1; w++; end
    if (!req_ready_o[r]) begin ok = 1'b0; req_valid_i[r] = 1'b0; return; end
    step();
    req_valid_i[r] = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin step(); lat++; end
    if (!rsp_valid_o) begin ok = 1'b0; return; end
    d  = rsp_data_o;
    id = rsp_id_o;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o, rsp_data_o,
         rsp_id_o, busy_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ena=%b wea=%b addr=%0h din=%0h rv=%b data=%0h id=%0h busy=%b rdy=%b, all required 0",
               acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o, req_ready_o);
    end
    rst_ni = 1'b1;
    step();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy_o); end
    req_valid_i = 2'b11;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL reset_rr_ptr: ready=%b required 01", req_ready_o); end
    req_valid_i = 2'b00;
    #1;
  endtask

  task automatic test_single();
    wr_q.delete();
    req_op1_i[31:0] = 32'd5;
    req_op2_i[31:0] = 32'd7;
    req_valid_i[0] = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_ready: ready=%b required 01", req_ready_o); end
    step();  // accept edge
    req_valid_i[0] = 1'b0;
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, busy_o} !== {1'b1, 1'b1, 11'd0, 32'd5, 1'b1}) begin
      n_fail++; $display("FAIL single_wr_op1: ena=%b wea=%b addr=%0d din=%0d busy=%b required 1 1 0 5 1",
                         acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, busy_o);
    end
    step();
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o} !== {1'b1, 1'b1, 11'd1, 32'd7}) begin
      n_fail++; $display("FAIL single_wr_op2: ena=%b wea=%b addr=%0d din=%0d required 1 1 1 7",
                         acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o);
    end
    step();
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o} !== {1'b1, 1'b0, 11'd2, 32'd0}) begin
      n_fail++; $display("FAIL single_rd_res: ena=%b wea=%b addr=%0d din=%0d required 1 0 2 0",
                         acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o);
    end
    step();
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o} !== '0) begin
      n_fail++; $display("FAIL single_wait_res: ena=%b wea=%b addr=%0d din=%0d rv=%b required all 0",
                         acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o);
    end
    step();
    n_checks++;
    if ({rsp_valid_o, rsp_data_o, rsp_id_o} !== {1'b1, 32'd12, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: rv=%b data=%0d id=%0d required 1 12 0", rsp_valid_o, rsp_data_o, rsp_id_o);
    end
    step();
    n_checks++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL single_back_idle: rv=%b busy=%b required 0 0", rsp_valid_o, busy_o);
    end
    n_checks++;
    if (wr_q.size() != 2 || wr_q[0] !== 11'd0 || wr_q[1] !== 11'd1) begin
      n_fail++; $display("FAIL single_write_seq: %0d writes logged, required addr 0 then 1", wr_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [ID_W-1:0] id; int lat; bit ok;
    do_op(1, 32'hFFFF_FFFF, 32'd2, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0001 || id !== 1'b1 || lat != 5) begin
      n_fail++; $display("FAIL overflow: ok=%0d data=%h id=%0d lat=%0d required 1 00000001 1 5", ok, d, id, lat);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    logic [31:0] exp_d;
    int w;
    exp_q.delete();
    exp_q.push_back(32'd2);  exp_q.push_back(32'd30);
    exp_q.push_back(32'd2);  exp_q.push_back(32'd30);
    req_op1_i = {32'd10, 32'd1};
    req_op2_i = {32'd20, 32'd1};
    req_valid_i = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      while (req_ready_o == 2'b00 && w < 20) begin step(); #1; w++; end
      n_checks++;
      if (req_ready_o !== exp_gnt) begin
        n_fail++; $display("FAIL contention_grant%0d: ready=%b required %b", t, req_ready_o, exp_gnt);
      end
      step();
      w = 0;
      while (!rsp_valid_o && w < 20) begin step(); w++; end
      exp_d = exp_q.pop_front();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_d || rsp_id_o !== ID_W'(t % 2)) begin
        n_fail++; $display("FAIL contention_rsp%0d: rv=%b data=%0d id=%0d required 1 %0d %0d",
                           t, rsp_valid_o, rsp_data_o, rsp_id_o, exp_d, t % 2);
      end
      step();
    end
    req_valid_i = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    int w;
    rsp_ready_i = 1'b0;
    req_op1_i[31:0] = 32'd100;
    req_op2_i[31:0] = 32'd23;
    req_valid_i[0] = 1'b1;
    #1;
    w = 0;
    while (!req_ready_o[0] && w < 20) begin step(); #1; w++; end
    step();
    req_valid_i = 2'b11;  // requester 1 still holds 10 + 20
    w = 0;
    while (!rsp_valid_o && w < 20) begin step(); w++; end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_data_o, rsp_id_o, req_ready_o, acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o}
          !== {1'b1, 32'd123, 1'b0, 2'b00, 1'b0, 1'b0, 11'd0, 32'd0}) begin
        n_fail++; $display("FAIL backpressure_hold%0d: rv=%b data=%0d id=%0d rdy=%b ena=%b wea=%b addr=%0d din=%0d required 1 123 0 00 0 0 0 0",
                           c, rsp_valid_o, rsp_data_o, rsp_id_o, req_ready_o, acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o);
      end
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL backpressure_release_cycle: ready=%b required 00", req_ready_o); end
    step();
    n_checks++;
    if ({rsp_valid_o, req_ready_o} !== 3'b0_10) begin
      n_fail++; $display("FAIL backpressure_next_accept: rv=%b ready=%b required 0 10", rsp_valid_o, req_ready_o);
    end
    req_valid_i = 2'b00;  // withdraw before acceptance
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic [ID_W-1:0] id; int lat; bit ok; int w;
    req_op1_i[31:0] = 32'd50;
    req_op2_i[31:0] = 32'd60;
    req_valid_i[0] = 1'b1;
    #1;
    w = 0;
    while (!req_ready_o[0] && w < 20) begin step(); #1; w++; end
    step();
    req_valid_i[0] = 1'b0;
    step();
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o} !== {1'b1, 1'b1, 11'd1}) begin
      n_fail++; $display("FAIL midop_in_wr_op2: ena=%b wea=%b addr=%0d required 1 1 1", acc_ena_o, acc_wea_o, acc_addr_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o, req_ready_o} !== '0) begin
      n_fail++; $display("FAIL midop_async_reset: ena=%b wea=%b addr=%0d din=%0d rv=%b data=%0d id=%0d busy=%b rdy=%b required all 0",
                         acc_ena_o, acc_wea_o, acc_addr_o, acc_din_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o, req_ready_o);
    end
    step();
    rst_ni = 1'b1;
    step();
    step();
    n_checks++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL midop_no_response: rv=%b busy=%b required 0 0", rsp_valid_o, busy_o);
    end
    do_op(0, 32'd3, 32'd4, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'd7 || id !== 1'b0 || lat != 5) begin
      n_fail++; $display("FAIL midop_fresh_op: ok=%0d data=%0d id=%0d lat=%0d required 1 7 0 5", ok, d, id, lat);
    end
  endtask

  task automatic test_skip();
    logic [31:0] d; logic [ID_W-1:0] id; int lat; bit ok;
    wr_q.delete();
    do_op(0, 32'd5, 32'd7, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'd12 || lat != 5 || wr_q.size() != 2) begin
      n_fail++; $display("FAIL skip_first: ok=%0d data=%0d lat=%0d writes=%0d required 1 12 5 2", ok, d, lat, wr_q.size());
    end
`ifdef ACCEL_SCHED_SKIP_EN
    wr_q.delete();
    do_op(0, 32'd5, 32'd9, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'd14 || lat != 4 || wr_q.size() != 1 ||
        (wr_q.size() == 1 ? wr_q[0] : 11'h7ff) !== 11'd1) begin
      n_fail++; $display("FAIL skip_op1: ok=%0d data=%0d lat=%0d writes=%0d required 1 14 4 1 (addr 1)", ok, d, lat, wr_q.size());
    end
    wr_q.delete();
    do_op(0, 32'd5, 32'd9, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'd14 || lat != 3 || wr_q.size() != 0) begin
      n_fail++; $display("FAIL skip_both: ok=%0d data=%0d lat=%0d writes=%0d required 1 14 3 0", ok, d, lat, wr_q.size());
    end
`else
    do_op(0, 32'd5, 32'd9, d, id, lat, ok);
    wr_q.delete();
    do_op(0, 32'd5, 32'd9, d, id, lat, ok);
    n_checks++;
    if (!ok || d !== 32'd14 || lat != 5 || wr_q.size() != 2) begin
      n_fail++; $display("FAIL repeat_no_skip: ok=%0d data=%0d lat=%0d writes=%0d required 1 14 5 2", ok, d, lat, wr_q.size());
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_op_scheduler.md
Name: accel_op_scheduler

Overview:
- Shares the single memory-mapped adder accelerator port between NUM_REQ requesters.
- Each requester submits an (op1, op2) pair over valid/ready. The block round-robin arbitrates and sequences the accelerator transaction: write op1, write op2, read result.
- It returns the 32-bit sum tagged with the requester id.
- It sits between the CPU/DMA-side requesters and the accelerator's clka/ena/wea/addra/dina/douta port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ) (min 1), width of the response id

Ports:
- clka  in  1  clock, shared with the accelerator
- rst_ni  in  1  reset, asynchronous, active-low; also resets the accelerator
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero
- req_op1_i  in  NUM_REQ*32  packed op1, requester i at bits [32i+31:32i]
- req_op2_i  in  NUM_REQ*32  packed op2, same packing
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumer ready
- rsp_data_o  out  32  op1+op2 mod 2^32
- rsp_id_o  out  ID_W  index of the requester that issued the request
- acc_ena_o  out  1  accelerator ena
- acc_wea_o  out  1  accelerator wea
- acc_addr_o  out  11  accelerator addra
- acc_din_o  out  32  accelerator dina
- acc_dout_i  in  32  accelerator douta, registered, valid the cycle after a read
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; result/id/operand registers 0.
- Reset mid-operation aborts the transaction immediately. No response is issued for it, and the accelerator is reset by the same rst_ni.
- FSM states: IDLE, WR_OP1, WR_OP2, RD_RES, WAIT_RES, RESP.
- IDLE:
  - The arbiter selects the first asserted req_valid_i at or after the rr pointer (wrap-around).
  - req_ready_o[grant] = 1 combinationally, only in IDLE.
  - On handshake: latch op1, op2, id; rr pointer <= (grant+1) mod NUM_REQ; go to WR_OP1.
  - With no valid request, stay in IDLE with the pointer unchanged.
- WR_OP1: ena=1, wea=1, addr=0, din=op1; next state WR_OP2.
- WR_OP2: ena=1, wea=1, addr=1, din=op2; next state RD_RES.
- RD_RES: ena=1, wea=0, addr=2; next state WAIT_RES.
- WAIT_RES: ena=0; capture acc_dout_i into the result register; next state RESP.
- RESP:
  - rsp_valid_o=1; rsp_data_o and rsp_id_o are held stable until rsp_ready_i.
  - On handshake, go to IDLE. A new request is accepted no earlier than the following cycle.
- Outside the write and read states: acc_ena_o=0, acc_wea_o=0, acc_addr_o=0, acc_din_o=0.
- Latency: request accepted at edge 0 -> rsp_valid_o high in cycle 5, with 4 accelerator-port cycles.
- Throughput: one operation per 6 cycles when rsp_ready_i is tied high.
- Backpressure: rsp_ready_i low holds RESP indefinitely. Requesters see req_ready_o=0 throughout.
- Arithmetic is performed by the accelerator. Overflow wraps, e.g. 0xFFFFFFFF+2 -> 0x00000001.
- A requester deasserting valid before ready is legal. Once accepted, the operands are already latched.

Optional Feature:
- Macro: ACCEL_SCHED_SKIP_EN.
- When defined:
  - The block keeps shadow registers of the last op1/op2 written to the accelerator (reset 0, matching accelerator reset).
  - WR_OP1 is skipped when op1 equals its shadow; WR_OP2 is skipped when op2 equals its shadow.
  - The FSM goes directly to the next needed state from IDLE/WR_OP1.
  - Minimum latency is 3 cycles (both skipped: IDLE -> RD_RES).
- When undefined: no shadows; every transaction performs both writes.

Decomposition:
- Package accel_sched_pkg contains:
  - state enum sched_state_e
  - ACC_ADDR_OP1=11'd0, ACC_ADDR_OP2=11'd1, ACC_ADDR_RES=11'd2
  - ACC_ADDR_W=11, ACC_DATA_W=32
- Sub-module accel_rr_arbiter(NUM_REQ):
  - inputs: request vector, pointer
  - outputs: one-hot grant, grant index, any_grant
  - purely combinational.

Test Plan:
- Single request: requester 0 submits op1=5, op2=7 -> port sequence {wr 0 =5, wr 1 =7, rd 2}; rsp_data_o=12, rsp_id_o=0 in cycle 5.
- Overflow: op1=0xFFFFFFFF, op2=2 -> rsp_data_o=0x00000001.
- Contention: both requesters valid continuously, rr pointer 0 -> grants alternate 0,1,0,1; results 1+1=2 (id 0), 10+20=30 (id 1).
- Backpressure: rsp_ready_i low for 10 cycles -> rsp_valid_o held, data stable, req_ready_o=0, accelerator port idle; release -> next request accepted one cycle after the handshake.
- Reset mid-op: assert rst_ni low during WR_OP2 -> all outputs 0 asynchronously, state IDLE; after release a fresh request 3+4 returns 7.
- ACCEL_SCHED_SKIP_EN: requests (5,7) then (5,9) -> the second transaction writes only addr 1, rsp_valid_o arrives 1 cycle earlier, result 14. Repeating (5,9) -> no writes, result 14 at latency 3.
